mem_cas_ctrl: RTL and testbench
===============================

# mem_cas_ctrl

Single-ported memory controller directly downstream of the allocator LSU. It terminates the LSU's `mem_req_*`/`mem_rsp_*` handshake and serves load, store and compare-and-swap requests against a local word-addressed SRAM holding the free-list headers and lock words. It returns exactly one response per accepted request, with CAS made atomic by construction: there is one requester and the read-compare-write is not interruptible.

## Interface
- `DATA_W`, from `allocator_pkg`: data and address width.
- `DEPTH`, default 1024: SRAM words. Must be a power of 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `mem_req_val_i` in 1: request valid.
- `mem_req_rdy_o` out 1: controller ready; reset 0.
- `mem_req_is_write_i` in 1: 1 = store, 0 = load. Ignored when `is_cas` = 1.
- `mem_req_is_cas_i` in 1: 1 = compare-and-swap.
- `mem_req_addr_i` in DATA_W: byte address.
- `mem_req_data_i` in DATA_W: store data, or the CAS new value.
- `mem_rsp_val_o` out 1: response valid; reset 0.
- `mem_rsp_rdy_i` in 1: LSU ready for the response.
- `mem_rsp_data_o` out DATA_W: response data; reset '0.
- `mem_rsp_err_o` out 1: address error, qualified by `mem_rsp_val_o`; reset 0.
- `cas_fail_cnt_o` out 16: count of failed CAS operations. Saturating; reset 0.

## Operation
- Word index = `addr >> $clog2(DATA_W/8)`.
- An address is an error if either holds:
  - the low `$clog2(DATA_W/8)` bits are non-zero;
  - the word index ≥ DEPTH.
- An error request performs no SRAM access. Its response is data '0, err 1.
- States:
  - IDLE: `mem_req_rdy_o` = 1. Handshake is `val & rdy`.
    - Store: SRAM write on the handshake edge, then go to RSP with data '0.
    - Load or CAS: SRAM read issued on the handshake edge; latch op and addr; go to ACC.
    - Error: go to RSP.
  - ACC: SRAM read data is valid.
    - Load: `rsp_data_q` ← rdata.
    - CAS with rdata == `EMPTY_KEY`: SRAM write of the latched new value on this edge; `rsp_data_q` ← `CAS_OK` ('0).
    - CAS with rdata ≠ `EMPTY_KEY`: no write; `rsp_data_q` ← `CAS_FAIL` ('1); `cas_fail_cnt` +1, saturating at 16'hFFFF.
    - Always go to RSP.
  - RSP: `mem_rsp_val_o` = 1; data and err are held stable. On `mem_rsp_rdy_i`, go to IDLE.
- `mem_req_rdy_o` is 0 in ACC and RSP. Only one transaction is in flight; a new request is not accepted in the same cycle as a response handshake.
- Priority: `is_cas` overrides `is_write`.
- Request inputs are sampled only on the handshake edge. Changes while `rdy` = 0 are ignored.
- SRAM contents are not reset.

## Timing
- Store or error: `mem_rsp_val_o` rises 1 cycle after the accept edge.
- Load or CAS: `mem_rsp_val_o` rises 2 cycles after the accept edge.
- Best-case throughput, with `mem_rsp_rdy_i` held at 1:
  - store: one request per 2 cycles;
  - load or CAS: one request per 3 cycles.
- Backpressure: RSP is held indefinitely while `mem_rsp_rdy_i` = 0, with no loss or change of data.
- Reset mid-operation: all outputs go to their reset values immediately and state goes to IDLE; the pending response is dropped.
  - A store, or a CAS write, already committed on an earlier edge remains in the SRAM.
  - A CAS in ACC at reset assertion performs no write.
- Load of a word in the cycle after a store to the same word returns the new data. There is no read-during-write hazard, because requests are serialized.

## Structure
- Add to `allocator_pkg`:
  - `CAS_OK` and `CAS_FAIL` constants;
  - the `mem_ctrl_state_e` enum (IDLE, ACC, RSP).
- `allocator_pkg` already provides `DATA_W` and `EMPTY_KEY`.
- Sub-module `sp_sram`: single-port synchronous RAM with 1-cycle read latency and write-first behaviour. Parameters `DATA_W` and `DEPTH`; ports `clk_i`, `en_i`, `we_i`, `addr_i`, `wdata_i`, `rdata_o`.
- `mem_cas_ctrl` contains the FSM, error checking, the response register and the counter.

## Test plan
- Store 0x1234 to 0x40, then load 0x40: store response data 0 arrives 1 cycle after accept; load response data 0x1234 arrives 2 cycles after accept; err 0.
- Store `EMPTY_KEY` to 0x80, then CAS 0x80 with new value 0x7: response 0, and a following load of 0x80 returns 0x7. A second CAS to 0x80 with 0x9: response '1, memory still 0x7, `cas_fail_cnt_o` = 1.
- Hold `mem_rsp_rdy_i` = 0 for 5 cycles after a load of 0x40: `mem_rsp_val_o` stays 1 with data 0x1234 throughout, and `mem_req_rdy_o` stays 0.
- Load 0x41 (misaligned), then load `DEPTH*(DATA_W/8)` (out of range): each gives err 1, data 0; the contents of word 0 are unchanged.
- Assert `rst_i` while in ACC of a CAS to an `EMPTY_KEY` word: outputs return to reset values, the word still reads `EMPTY_KEY`, and the next request is accepted normally.
- Back-to-back random mix of 200 loads, stores and CASes against a scoreboard model: every response matches the model, and there is exactly one response per accept.

Source files
------------

// File: rtl/allocator_pkg.sv
// -----------------------------------------------------------------------------
// allocator_pkg
//   Shared definitions for the allocator memory path.
//   - DATA_W       : data and byte-address width of the LSU memory interface
//   - EMPTY_KEY    : value marking a free header / unlocked word
//   - CAS_OK       : CAS response when the swap took place
//   - CAS_FAIL     : CAS response when the word was not EMPTY_KEY
//   - BYTE_OFF_W   : number of byte-offset bits inside one word
//   - mem_ctrl_state_e : state encoding of the mem_cas_ctrl FSM
//   - addr_is_err  : misaligned / out-of-range address check
// -----------------------------------------------------------------------------
package allocator_pkg;

   localparam int DATA_W     = 32;
   localparam int BYTE_OFF_W = $clog2(DATA_W / 8);

   localparam logic [DATA_W-1:0] EMPTY_KEY = 32'hFFFF_0000;
   localparam logic [DATA_W-1:0] CAS_OK    = '0;
   localparam logic [DATA_W-1:0] CAS_FAIL  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RSP  = 2'd2
   } mem_ctrl_state_e;

   // A byte address is unusable when it does not point at the first byte of a
   // word, or when its word index falls beyond the end of the SRAM.
   function automatic logic addr_is_err(input logic [DATA_W-1:0] addr,
                                        input int unsigned        depth);
      logic [DATA_W-1:0] word_idx;
      logic              misaligned;
      logic              out_of_range;
      word_idx     = addr >> BYTE_OFF_W;
      misaligned   = |addr[BYTE_OFF_W-1:0];
      out_of_range = (word_idx >= DATA_W'(depth));
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/sp_sram.sv
// -----------------------------------------------------------------------------
// sp_sram
//   Single-port synchronous RAM, one-cycle read latency, write-first: a write
//   also returns the written data on rdata_o on the following cycle.
//   Contents are not reset.
//   Ports:
//     clk_i    in  : clock
//     en_i     in  : access enable (read or write)
//     we_i     in  : write enable, qualified by en_i
//     addr_i   in  : word address
//     wdata_i  in  : write data
//     rdata_o  out : read data, valid the cycle after an enabled access
// -----------------------------------------------------------------------------
module sp_sram #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem[addr_i] <= wdata_i;
            rdata_o     <= wdata_i;
         end else begin
            rdata_o     <= mem[addr_i];
         end
      end
   end

endmodule

// File: rtl/mem_cas_ctrl.sv
// -----------------------------------------------------------------------------
// mem_cas_ctrl
//   Memory controller behind the allocator LSU. Serves load, store and
//   compare-and-swap requests against a local word-addressed SRAM, one
//   transaction at a time, returning exactly one response per accepted
//   request. CAS is atomic because the read-compare-write sequence cannot be
//   interleaved with any other request.
//   Ports:
//     clk_i              in  : clock
//     rst_i              in  : asynchronous active-high reset
//     mem_req_val_i      in  : request valid
//     mem_req_rdy_o      out : controller ready (IDLE only)
//     mem_req_is_write_i in  : 1 = store, 0 = load (ignored for CAS)
//     mem_req_is_cas_i   in  : 1 = compare-and-swap
//     mem_req_addr_i     in  : byte address
//     mem_req_data_i     in  : store data / CAS new value
//     mem_rsp_val_o      out : response valid
//     mem_rsp_rdy_i      in  : LSU ready for the response
//     mem_rsp_data_o     out : response data
//     mem_rsp_err_o      out : address error, qualified by mem_rsp_val_o
//     cas_fail_cnt_o     out : saturating count of failed CAS operations
// -----------------------------------------------------------------------------
module mem_cas_ctrl
   import allocator_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_req_val_i,
   output logic              mem_req_rdy_o,
   input  logic              mem_req_is_write_i,
   input  logic              mem_req_is_cas_i,
   input  logic [DATA_W-1:0] mem_req_addr_i,
   input  logic [DATA_W-1:0] mem_req_data_i,
   output logic              mem_rsp_val_o,
   input  logic              mem_rsp_rdy_i,
   output logic [DATA_W-1:0] mem_rsp_data_o,
   output logic              mem_rsp_err_o,
   output logic [15:0]       cas_fail_cnt_o
);

   localparam int ADDR_W = $clog2(DEPTH);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   mem_ctrl_state_e   state_q;
   logic              rdy_q;
   logic              rsp_val_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;
   logic [15:0]       cas_fail_cnt_q;
   logic              op_cas_q;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [DATA_W-1:0] word_idx;
   logic              req_err;
   logic              req_store;
   logic              accept;
   logic              rdata_empty;
   logic              cas_hit;

   logic              sram_en;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   // ---- request decode (IDLE) ----
   assign word_idx    = mem_req_addr_i >> BYTE_OFF_W;
   assign req_err     = addr_is_err(mem_req_addr_i, DEPTH);
   assign req_store   = ~mem_req_is_cas_i & mem_req_is_write_i;
   assign accept      = rdy_q & mem_req_val_i;

   // ---- SRAM result evaluation (ACC) ----
   assign rdata_empty = (sram_rdata == EMPTY_KEY);
   assign cas_hit     = (state_q == ACC) & op_cas_q & rdata_empty;

   // rst_i gates the enables combinationally so a CAS caught in ACC by an
   // asynchronous reset can never commit its write on the next edge.
   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = word_idx[ADDR_W-1:0];
      sram_wdata = mem_req_data_i;
      if (state_q == ACC) begin
         sram_addr  = addr_q;
         sram_wdata = wdata_q;
      end
      if (!rst_i) begin
         if (accept && !req_err) begin
            sram_en = 1'b1;
            sram_we = req_store;
         end else if (cas_hit) begin
            sram_en = 1'b1;
            sram_we = 1'b1;
         end
      end
   end

   sp_sram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_sram (
      .clk_i   (clk_i),
      .en_i    (sram_en),
      .we_i    (sram_we),
      .addr_i  (sram_addr),
      .wdata_i (sram_wdata),
      .rdata_o (sram_rdata)
   );

   // Latched request fields: only meaningful while a load/CAS is in ACC.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q  <= word_idx[ADDR_W-1:0];
         wdata_q <= mem_req_data_i;
      end
   end

   // ---- FSM and registered outputs ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         rdy_q          <= 1'b0;
         rsp_val_q      <= 1'b0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         cas_fail_cnt_q <= '0;
         op_cas_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               rdy_q <= 1'b1;
               if (accept) begin
                  rdy_q    <= 1'b0;
                  op_cas_q <= mem_req_is_cas_i;
                  if (req_err) begin
                     rsp_val_q  <= 1'b1;
                     rsp_data_q <= '0;
                     rsp_err_q  <= 1'b1;
                     state_q    <= RSP;
                  end else if (req_store) begin
                     rsp_val_q  <= 1'b1;
                     rsp_data_q <= '0;
                     rsp_err_q  <= 1'b0;
                     state_q    <= RSP;
                  end else begin
                     state_q    <= ACC;
                  end
               end
            end
            ACC: begin
               rsp_val_q <= 1'b1;
               rsp_err_q <= 1'b0;
               state_q   <= RSP;
               if (!op_cas_q) begin
                  rsp_data_q <= sram_rdata;
               end else if (rdata_empty) begin
                  rsp_data_q <= CAS_OK;
               end else begin
                  rsp_data_q     <= CAS_FAIL;
                  cas_fail_cnt_q <= sat_inc16(cas_fail_cnt_q);
               end
            end
            RSP: begin
               // Ready is raised only after the response handshake, so a new
               // request can never be accepted in the same cycle.
               if (mem_rsp_rdy_i) begin
                  rsp_val_q <= 1'b0;
                  rdy_q     <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: begin
               rsp_val_q <= 1'b0;
               rdy_q     <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign mem_req_rdy_o  = rdy_q;
   assign mem_rsp_val_o  = rsp_val_q;
   assign mem_rsp_data_o = rsp_data_q;
   assign mem_rsp_err_o  = rsp_err_q;
   assign cas_fail_cnt_o = cas_fail_cnt_q;

endmodule

// File: tb/tb_mem_cas_ctrl.sv
module tb_mem_cas_ctrl;
   import allocator_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        mem_req_val_i = 1'b0;
   logic        mem_req_rdy_o;
   logic        mem_req_is_write_i = 1'b0;
   logic        mem_req_is_cas_i = 1'b0;
   logic [31:0] mem_req_addr_i = '0;
   logic [31:0] mem_req_data_i = '0;
   logic        mem_rsp_val_o;
   logic        mem_rsp_rdy_i = 1'b1;
   logic [31:0] mem_rsp_data_o;
   logic        mem_rsp_err_o;
   logic [15:0] cas_fail_cnt_o;

   always #5 clk = ~clk;

   mem_cas_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .mem_req_val_i      (mem_req_val_i),
      .mem_req_rdy_o      (mem_req_rdy_o),
      .mem_req_is_write_i (mem_req_is_write_i),
      .mem_req_is_cas_i   (mem_req_is_cas_i),
      .mem_req_addr_i     (mem_req_addr_i),
      .mem_req_data_i     (mem_req_data_i),
      .mem_rsp_val_o      (mem_rsp_val_o),
      .mem_rsp_rdy_i      (mem_rsp_rdy_i),
      .mem_rsp_data_o     (mem_rsp_data_o),
      .mem_rsp_err_o      (mem_rsp_err_o),
      .cas_fail_cnt_o     (cas_fail_cnt_o)
   );

   int n_pass = 0;
   int n_tot  = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      n_tot++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
   endfunction

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          acc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [int];
   logic [15:0] model_cnt = '0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Response-ready driver: forced low until bp_until, random when rand_bp.
   int bp_until = 0;
   bit rand_bp  = 1'b0;
   always @(posedge clk) begin
      #1;
      if (cyc < bp_until)  mem_rsp_rdy_i = 1'b0;
      else if (rand_bp)    mem_rsp_rdy_i = ($urandom_range(0, 2) != 0);
      else                 mem_rsp_rdy_i = 1'b1;
   end

   // Reference model: memory as a sparse array, evaluated at accept time.
   function automatic exp_t model_op(input logic w, input logic c,
                                     input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      int   idx;
      e.data = 32'h0; e.err = 1'b0; e.lat = 1; e.acc = 0;
      idx = int'(a >> 2);
      if (a[1:0] != 2'b00 || (a >> 2) >= 32'(DEPTH)) begin
         e.err = 1'b1;
      end else if (c) begin
         e.lat = 2;
         if (model_mem[idx] == EMPTY_KEY) begin
            model_mem[idx] = d;
            e.data = 32'h0000_0000;
         end else begin
            e.data = 32'hFFFF_FFFF;
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
         end
      end else if (w) begin
         model_mem[idx] = d;
      end else begin
         e.lat  = 2;
         e.data = model_mem[idx];
      end
      e.cnt = model_cnt;
      return e;
   endfunction

   // Compare process: every response cycle is checked against the queue head.
   int   rd_idx = 0;
   bit   seen_first = 1'b0;
   exp_t cur;
   always @(negedge clk) begin
      if (rst_i) begin
         rd_idx     = exp_q.size();
         seen_first = 1'b0;
      end else if (mem_rsp_val_o) begin
         if (rd_idx >= exp_q.size()) begin
            check("spurious_rsp", 32'(mem_rsp_val_o), 32'h0);
         end else begin
            cur = exp_q[rd_idx];
            if (!seen_first) begin
               check("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
               seen_first = 1'b1;
            end
            check("rsp_data", mem_rsp_data_o, cur.data);
            check("rsp_err", 32'(mem_rsp_err_o), 32'(cur.err));
            check("req_rdy_in_rsp", 32'(mem_req_rdy_o), 32'h0);
            if (mem_rsp_rdy_i) begin
               check("cas_fail_cnt", 32'(cas_fail_cnt_o), 32'(cur.cnt));
               rd_idx++;
               seen_first = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic w, input logic c, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e, output int acc);
      int waited = 0;
      @(negedge clk);
      mem_req_val_i      = 1'b1;
      mem_req_is_write_i = w;
      mem_req_is_cas_i   = c;
      mem_req_addr_i     = a;
      mem_req_data_i     = d;
      while (!mem_req_rdy_o && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!mem_req_rdy_o) begin
         check("req_accept_timeout", 32'(mem_req_rdy_o), 32'h1);
         mem_req_val_i = 1'b0;
         e = '{data: 32'h0, err: 1'b0, lat: 0, acc: 0, cnt: 16'h0};
         acc = -1;
         return;
      end
      acc   = cyc;
      e     = model_op(w, c, a, d);
      e.acc = acc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      // Garbage while not ready must be ignored by the controller.
      mem_req_val_i      = 1'b0;
      mem_req_addr_i     = $urandom;
      mem_req_data_i     = $urandom;
      mem_req_is_write_i = 1'($urandom);
      mem_req_is_cas_i   = 1'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((rd_idx != exp_q.size() || mem_rsp_val_o) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("drain_timeout", 32'(rd_idx), 32'(exp_q.size()));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp_t        e;
      int          a1, a2, n;
      logic [31:0] pool [8];
      logic [31:0] addr, data;
      int          op, k;
      logic        w, c;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_rdy", 32'(mem_req_rdy_o), 32'h0);
      check("rst_rsp_val", 32'(mem_rsp_val_o), 32'h0);
      check("rst_rsp_data", mem_rsp_data_o, 32'h0);
      check("rst_rsp_err", 32'(mem_rsp_err_o), 32'h0);
      check("rst_cnt", 32'(cas_fail_cnt_o), 32'h0);
      rst_i = 1'b0;

      // Store then load, with best-case spacing
      send(1'b1, 1'b0, 32'h40, 32'h1234, e, a1);
      check("pin_store_data", e.data, 32'h0);
      send(1'b1, 1'b0, 32'h44, 32'h1, e, a2);
      check("store_spacing", 32'(a2 - a1), 32'd2);
      send(1'b0, 1'b0, 32'h40, 32'h0, e, a1);
      check("pin_load_data", e.data, 32'h1234);
      send(1'b0, 1'b0, 32'h40, 32'h0, e, a2);
      check("load_spacing", 32'(a2 - a1), 32'd3);

      // CAS success then failure
      send(1'b1, 1'b0, 32'h80, EMPTY_KEY, e, a1);
      send(1'b0, 1'b1, 32'h80, 32'h7, e, a1);
      check("pin_cas_ok", e.data, 32'h0);
      send(1'b0, 1'b0, 32'h80, 32'h0, e, a1);
      check("pin_cas_written", e.data, 32'h7);
      send(1'b1, 1'b1, 32'h80, 32'h9, e, a1);
      check("pin_cas_fail", e.data, 32'hFFFF_FFFF);
      check("pin_cas_cnt", 32'(e.cnt), 32'h1);
      send(1'b0, 1'b0, 32'h80, 32'h0, e, a1);
      check("pin_cas_unchanged", e.data, 32'h7);
      drain();
      check("cnt_after_fail", 32'(cas_fail_cnt_o), 32'h1);

      // Backpressure: response held stable for at least 5 cycles
      bp_until = cyc + 12;
      send(1'b0, 1'b0, 32'h40, 32'h0, e, a1);
      n = 0;
      while (!mem_rsp_val_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_val", 32'(mem_rsp_val_o), 32'h1);
         check("bp_rsp_data", mem_rsp_data_o, 32'h1234);
         check("bp_req_rdy", 32'(mem_req_rdy_o), 32'h0);
         @(negedge clk);
      end
      drain();

      // Address errors leave word 0 untouched
      send(1'b1, 1'b0, 32'h0, 32'hA5A5_0000, e, a1);
      send(1'b0, 1'b0, 32'h41, 32'h0, e, a1);
      check("pin_misaligned_err", 32'(e.err), 32'h1);
      send(1'b0, 1'b0, 32'(DEPTH * 4), 32'h0, e, a1);
      check("pin_range_err", 32'(e.err), 32'h1);
      send(1'b1, 1'b0, 32'h2, 32'h5555_5555, e, a1);
      send(1'b0, 1'b1, 32'(DEPTH * 4 + 8), 32'h5555_5555, e, a1);
      send(1'b0, 1'b0, 32'h0, 32'h0, e, a1);
      check("pin_word0", e.data, 32'hA5A5_0000);
      drain();

      // Reset while a CAS to an EMPTY_KEY word sits in ACC
      send(1'b1, 1'b0, 32'h80, EMPTY_KEY, e, a1);
      drain();
      @(negedge clk);
      mem_req_val_i      = 1'b1;
      mem_req_is_write_i = 1'b0;
      mem_req_is_cas_i   = 1'b1;
      mem_req_addr_i     = 32'h80;
      mem_req_data_i     = 32'h55;
      n = 0;
      while (!mem_req_rdy_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2;
      rst_i         = 1'b1;
      mem_req_val_i = 1'b0;
      #1;
      check("midrst_rsp_val", 32'(mem_rsp_val_o), 32'h0);
      check("midrst_req_rdy", 32'(mem_req_rdy_o), 32'h0);
      check("midrst_rsp_data", mem_rsp_data_o, 32'h0);
      check("midrst_cnt", 32'(cas_fail_cnt_o), 32'h0);
      model_cnt = '0;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      send(1'b0, 1'b0, 32'h80, 32'h0, e, a1);
      check("pin_midrst_word", e.data, EMPTY_KEY);
      drain();

      // Random mix against the model, with random response backpressure
      rand_bp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pool[i] = 32'h100 + 32'(4 * i);
         send(1'b1, 1'b0, pool[i], ($urandom_range(0, 1) != 0) ? EMPTY_KEY : $urandom,
              e, a1);
      end
      for (int i = 0; i < 200; i++) begin
         op = $urandom_range(0, 2);
         k  = $urandom_range(0, 7);
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) != 0) addr = pool[k] + 32'($urandom_range(1, 3));
            else addr = 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 100));
         end else begin
            addr = pool[k];
         end
         w = (op == 1) || (op == 2 && $urandom_range(0, 1) != 0);
         c = (op == 2);
         data = ($urandom_range(0, 1) != 0) ? EMPTY_KEY : $urandom;
         send(w, c, addr, data, e, a1);
      end
      drain();
      rand_bp = 1'b0;
      check("rsp_per_accept", 32'(rd_idx), 32'(exp_q.size()));
      check("final_cnt", 32'(cas_fail_cnt_o), 32'(model_cnt));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
